// File: rtl/tanh_pkg.sv
// tanh activation shared constants: S7.8 formats, LUT bounds, saturation magnitude.
// Used by the tanh address calculator and the LUT reader back end.
// Holds pure constants and helpers only; it contains no state.
package tanh_pkg;

  localparam int INPUT_WIDTH = 16;
  localparam int ADDR_WIDTH  = 9;
  localparam int FRAC_BITS   = 8;
  localparam int MAX_ADDR    = 275;
  localparam int SAT_WIDTH   = 16;

  // 1.0 in S7.8, and the region bounds the address calculator splits on
  localparam logic [INPUT_WIDTH-1:0] ONE_S78   = 16'h0100;
  localparam logic [INPUT_WIDTH-1:0] INPUT_MIN = 16'h0040;  // 0.25
  localparam logic [INPUT_WIDTH-1:0] INPUT_MAX = 16'h0300;  // 3.0
  // largest magnitude below 1.0 (0.996), returned for |x| > 3.0
  localparam logic [INPUT_WIDTH-1:0] SAT_VALUE = 16'h00FF;

  // request flags carried alongside the data through the S1 stage
  typedef struct packed {
    logic use_sym;
    logic sat_low;
    logic sat_high;
  } s1_ctl_t;

  // saturating increment for the 16-bit saturation event counter
  function automatic logic [SAT_WIDTH-1:0] sat_inc16(input logic [SAT_WIDTH-1:0] cnt);
    return (cnt == {SAT_WIDTH{1'b1}}) ? cnt : cnt + {{(SAT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/tanh_out_fifo.sv
// 2-entry result FIFO for the tanh LUT reader output side.
// Latency: a pushed entry is visible on o_dat/o_vld the cycle after the push (no bypass).
// Backpressure: head holds stable until popped; push on full is accepted only with a same-cycle pop.
module tanh_out_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_dat,
  input  logic                  i_pop,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic [1:0]            o_count
);

  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
  logic                  w_push;
  logic                  w_pop;

  // Qualify push/pop so a misbehaving neighbour can never corrupt the count.
  always_comb begin
    w_pop  = i_pop && (r_count != 2'd0);
    w_push = i_push && ((r_count != 2'd2) || w_pop);
  end

  // Storage, pointers and occupancy; a push while full overwrites the slot being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_vld   = (r_count != 2'd0);
  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/tanh_lut_reader.sv
// tanh back end: reads the magnitude ROM, applies saturation/linear region and odd symmetry.
// Latency: request accepted at N, ROM data and compose at N+1, result on out_valid at N+2.
// Backpressure: credits (FIFO entries + S1) capped at 2 so ROM data is never dropped when stalled.
module tanh_lut_reader #(
  parameter int INPUT_WIDTH = tanh_pkg::INPUT_WIDTH,
  parameter int ADDR_WIDTH  = tanh_pkg::ADDR_WIDTH,
  parameter int FRAC_BITS   = tanh_pkg::FRAC_BITS,
  parameter int MAX_ADDR    = tanh_pkg::MAX_ADDR,
  parameter logic [INPUT_WIDTH-1:0] SAT_VALUE = INPUT_WIDTH'((1 << FRAC_BITS) - 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_value,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic                   in_use_sym,
  input  logic                   in_sat_low,
  input  logic                   in_sat_high,
  output logic                   rom_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [INPUT_WIDTH-1:0] rom_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] out_value,
  output logic [15:0]            sat_count
);

  import tanh_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] L_MAX_ADDR = ADDR_WIDTH'(MAX_ADDR);

  // pipeline state
  logic                   r_ready_en;
  logic                   r_s1_vld;
  s1_ctl_t                r_s1_ctl;
  logic [INPUT_WIDTH-1:0] r_s1_value;
  logic [15:0]            r_sat_count;

  // combinational
  logic                   w_accept;
  logic                   w_sat_any;
  logic                   w_pop;
  logic [1:0]             w_fifo_count;
  logic [1:0]             w_credit;
  logic [ADDR_WIDTH-1:0]  w_addr_clamped;
  logic [INPUT_WIDTH-1:0] w_abs_value;
  logic [INPUT_WIDTH-1:0] w_mag;
  logic [INPUT_WIDTH-1:0] w_result;
  logic                   w_fifo_vld;
  logic [INPUT_WIDTH-1:0] w_fifo_dat;

  // Hold in_ready low through reset and for the reset-release edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  // Credit check and ROM request: one slot per in-flight item, whether or not it reads the ROM.
  always_comb begin
    w_pop          = w_fifo_vld && out_ready;
    w_credit       = w_fifo_count + {1'b0, r_s1_vld};
    in_ready       = r_ready_en &&
                     ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop));
    w_accept       = in_valid && in_ready;
    w_sat_any      = in_sat_low || in_sat_high;
    w_addr_clamped = (in_addr > L_MAX_ADDR) ? L_MAX_ADDR : in_addr;
    rom_en         = w_accept && !w_sat_any;
    rom_addr       = rom_en ? w_addr_clamped : '0;
  end

  // S1 stage: capture request flags/value so they line up with rom_data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_ctl   <= '0;
      r_s1_value <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_ctl.use_sym  <= in_use_sym;
        r_s1_ctl.sat_low  <= in_sat_low;
        r_s1_ctl.sat_high <= in_sat_high;
        r_s1_value        <= in_value;
      end
    end
  end

  // Compose: sat_high beats sat_low; linear region passes |x| through; negation of 0 stays 0.
  always_comb begin
    w_abs_value = r_s1_value[INPUT_WIDTH-1] ? (~r_s1_value + 1'b1) : r_s1_value;
    if (r_s1_ctl.sat_high) begin
      w_mag = SAT_VALUE;
    end else if (r_s1_ctl.sat_low) begin
      w_mag = w_abs_value;
    end else begin
      w_mag = rom_data;
    end
    w_result = r_s1_ctl.use_sym ? (~w_mag + 1'b1) : w_mag;
  end

  // Count accepted requests that skip the ROM, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (w_accept && w_sat_any) begin
      r_sat_count <= sat_inc16(r_sat_count);
    end
  end

  tanh_out_fifo #(
    .DATA_WIDTH (INPUT_WIDTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_s1_vld),
    .i_push_dat (w_result),
    .i_pop      (w_pop),
    .o_vld      (w_fifo_vld),
    .o_dat      (w_fifo_dat),
    .o_count    (w_fifo_count)
  );

  assign out_valid = w_fifo_vld;
  assign out_value = w_fifo_dat;
  assign sat_count = r_sat_count;

endmodule

// File: tb/tb_tanh_lut_reader.sv
// Directed bench for tanh_lut_reader with a behavioural ROM and an in-order scoreboard.
// Expected results are computed from the request fields when the request is accepted.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_tanh_lut_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [8:0]  in_addr;
  logic        in_use_sym;
  logic        in_sat_low;
  logic        in_sat_high;
  logic        rom_en;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data = 16'h0000;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic [15:0] sat_count;

  typedef struct packed {
    logic [15:0] v;
    logic [8:0]  a;
    logic        sym;
    logic        lo;
    logic        hi;
  } req_t;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  bit          acc = 1'b0;
  int          min_lat = 1000;
  int          max_lat = 0;
  int          pops = 0;
  int          sat_model = 0;
  bit          hold_pend = 1'b0;
  logic [15:0] hold_val = 16'h0000;

  always #5 clk = ~clk;

  tanh_lut_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .in_addr     (in_addr),
    .in_use_sym  (in_use_sym),
    .in_sat_low  (in_sat_low),
    .in_sat_high (in_sat_high),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .sat_count   (sat_count)
  );

  function automatic logic [15:0] rom_val(input logic [8:0] a);
    logic [15:0] r;
    case (a)
      9'd0:    r = 16'h003F;
      9'd77:   r = 16'h00C3;
      default: r = {8'h00, a[7:0] ^ 8'h5A};
    endcase
    return r;
  endfunction

  // synchronous ROM: data one cycle after the strobe
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_val(rom_addr);
  end

  function automatic logic [15:0] model(input logic [15:0] v, input logic [8:0] a,
                                        input logic sym, input logic lo, input logic hi);
    logic [15:0] mag;
    if (hi)      mag = 16'h00FF;
    else if (lo) mag = v[15] ? (~v + 16'd1) : v;
    else         mag = rom_val((a > 9'd275) ? 9'd275 : a);
    return sym ? (~mag + 16'd1) : mag;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: sample/score at the falling edge, return 1 unit after the next rising edge
  task automatic cycle();
    logic [15:0] e;
    int          t;
    logic        exp_rom;
    @(negedge clk);
    cyc++;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_value", out_value, hold_val);
    end
    hold_pend = out_valid && !out_ready;
    hold_val  = out_value;
    if (out_valid && out_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_mis++;
        $error("FAIL spurious_out observed=%0h expected=none", out_value);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = acc_q.pop_front();
        check("out_value", out_value, e);
        if (cyc - t > max_lat) max_lat = cyc - t;
        if (cyc - t < min_lat) min_lat = cyc - t;
        pops++;
      end
    end
    check("sat_count", sat_count, sat_model);
    acc     = in_valid && in_ready;
    exp_rom = acc && !in_sat_low && !in_sat_high;
    check("rom_en", rom_en, exp_rom);
    if (exp_rom) check("rom_addr", rom_addr, (in_addr > 9'd275) ? 9'd275 : in_addr);
    if (acc) begin
      exp_q.push_back(model(in_value, in_addr, in_use_sym, in_sat_low, in_sat_high));
      acc_q.push_back(cyc);
      if ((in_sat_low || in_sat_high) && sat_model < 65535) sat_model++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input req_t r);
    in_value    = r.v;
    in_addr     = r.a;
    in_use_sym  = r.sym;
    in_sat_low  = r.lo;
    in_sat_high = r.hi;
  endtask

  task automatic send(input logic [15:0] v, input logic [8:0] a,
                      input logic sym, input logic lo, input logic hi);
    load('{v: v, a: a, sym: sym, lo: lo, hi: hi});
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc) break;
    end
    check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  req_t bp_list[6];
  int   idx;
  int   c0;
  int   p0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    load('0);

    // reset state
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_high", in_ready, 1);

    // 1: single positive, exact latency 2
    min_lat = 1000; max_lat = 0;
    send(16'h0100, 9'd77, 1'b0, 1'b0, 1'b0);
    drain();
    check("t1_min_lat", min_lat, 2);
    check("t1_max_lat", max_lat, 2);

    // 2: negative symmetry via ROM, saturated high negated
    send(16'hFF00, 9'd0, 1'b1, 1'b0, 1'b0);
    send(16'hFC00, 9'd0, 1'b1, 1'b0, 1'b1);
    drain();

    // 3: linear region both signs
    send(16'h0020, 9'd0, 1'b0, 1'b1, 1'b0);
    send(16'hFFE0, 9'd0, 1'b1, 1'b1, 1'b0);
    drain();
    check("t3_sat_count", sat_count, 3);

    // 4: clamp and back-to-back stream with out_ready=1
    min_lat = 1000; max_lat = 0;
    c0 = cyc;
    send(16'h0180, 9'd300, 1'b0, 1'b0, 1'b0);
    send(16'h0050, 9'd5,   1'b0, 1'b0, 1'b0);
    send(16'hFF80, 9'd100, 1'b1, 1'b0, 1'b0);
    send(16'h0010, 9'd0,   1'b0, 1'b1, 1'b0);
    send(16'h0400, 9'd0,   1'b0, 1'b0, 1'b1);
    send(16'hFFF0, 9'd0,   1'b1, 1'b1, 1'b0);
    send(16'hFC00, 9'd0,   1'b1, 1'b1, 1'b1);
    send(16'h0090, 9'd276, 1'b0, 1'b0, 1'b0);
    check("t4_b2b_cycles", cyc - c0, 8);
    drain();
    check("t4_min_lat", min_lat, 2);
    check("t4_max_lat", max_lat, 2);

    // 5: backpressure
    bp_list[0] = '{v: 16'h00A0, a: 9'd10,  sym: 1'b0, lo: 1'b0, hi: 1'b0};
    bp_list[1] = '{v: 16'hFF60, a: 9'd20,  sym: 1'b1, lo: 1'b0, hi: 1'b0};
    bp_list[2] = '{v: 16'h0030, a: 9'd0,   sym: 1'b0, lo: 1'b1, hi: 1'b0};
    bp_list[3] = '{v: 16'h0500, a: 9'd0,   sym: 1'b0, lo: 1'b0, hi: 1'b1};
    bp_list[4] = '{v: 16'h0120, a: 9'd77,  sym: 1'b0, lo: 1'b0, hi: 1'b0};
    bp_list[5] = '{v: 16'hFEE0, a: 9'd400, sym: 1'b1, lo: 1'b0, hi: 1'b0};
    p0 = pops;
    out_ready = 1'b0;
    idx = 0;
    load(bp_list[0]);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (acc) begin
        idx++;
        if (idx < 6) load(bp_list[idx]);
      end
    end
    check("t5_accepted", idx, 2);
    check("t5_in_ready", in_ready, 0);
    check("t5_out_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (idx >= 6) break;
      cycle();
      if (acc) begin
        idx++;
        if (idx < 6) load(bp_list[idx]);
      end
    end
    in_valid = 1'b0;
    check("t5_all_sent", idx, 6);
    drain();
    check("t5_pops", pops - p0, 6);

    // 6: reset with two entries in flight
    out_ready = 1'b0;
    send(16'h0020, 9'd0,  1'b0, 1'b1, 1'b0);
    send(16'h0100, 9'd77, 1'b0, 1'b0, 1'b0);
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_value", out_value, 0);
    check("t6_sat_count", sat_count, 0);
    check("t6_in_ready", in_ready, 0);
    check("t6_rom_en", rom_en, 0);
    exp_q.delete();
    acc_q.delete();
    sat_model = 0;
    hold_pend = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t6_rel_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("t6_rel_in_ready_high", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    send(16'hFD00, 9'd0, 1'b1, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
